regfile_sb: RTL and testbench

Parametrised register file with registered read ports, same-cycle write-to-read bypass and an integrated per-register pending scoreboard. It replaces the single-cycle 32x32 register file in the pipelined datapath: decode reads operands and reserves its destination register, writeback writes the result and releases the reservation. Its busy flags give the hazard unit RAW and WAW stall information without a separate scoreboard.

---
 rtl/regfile_sb_if.sv | 35 +++
 rtl/regfile_sb.sv | 87 ++++++++
 tb/tb_regfile_sb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_if
// Brief    : Read / write / reservation bus of the scoreboarded register file.
// Revision : 1.0
// ============================================================================
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ok;

    modport master (
        output rd_en, ra1, ra2, we, wa, wd, rsv_en, rsv_addr,
        input  rd1, rd2, rd_busy1, rd_busy2, rsv_ok
    );

    modport slave (
        input  rd_en, ra1, ra2, we, wa, wd, rsv_en, rsv_addr,
        output rd1, rd2, rd_busy1, rd_busy2, rsv_ok
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Register file with registered reads, write bypass and pending bits.
// Revision : 1.0
// ============================================================================
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH    = 1 << ADDR_W;
    localparam bit c_ZERO_R0 = (ZERO_R0 != 0);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_busy1;
    logic              r_busy2;

    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic [DEPTH-1:0]  w_pend_nxt;
    logic [DATA_W-1:0] w_rd1_nxt;
    logic [DATA_W-1:0] w_rd2_nxt;

    assign w_wr_ok  = bus.we && !(c_ZERO_R0 && (bus.wa == '0));
    // A same-cycle write to the target frees it, so no one-cycle bubble appears.
    assign w_rsv_ok = bus.rsv_en && !(c_ZERO_R0 && (bus.rsv_addr == '0)) &&
                      (!r_pend[bus.rsv_addr] || (bus.we && (bus.wa == bus.rsv_addr)));

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_ok)
            w_pend_nxt[bus.wa] = 1'b0;
        if (w_rsv_ok)
            w_pend_nxt[bus.rsv_addr] = 1'b1;
    end

    always_comb begin
        w_rd1_nxt = r_regs[bus.ra1];
        if (w_wr_ok && (bus.wa == bus.ra1))
            w_rd1_nxt = bus.wd;
        else if (c_ZERO_R0 && (bus.ra1 == '0))
            w_rd1_nxt = '0;

        w_rd2_nxt = r_regs[bus.ra2];
        if (w_wr_ok && (bus.wa == bus.ra2))
            w_rd2_nxt = bus.wd;
        else if (c_ZERO_R0 && (bus.ra2 == '0))
            w_rd2_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_pend  <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_busy1 <= 1'b0;
            r_busy2 <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_regs[bus.wa] <= bus.wd;
            r_pend <= w_pend_nxt;
            if (bus.rd_en) begin
                r_rd1   <= w_rd1_nxt;
                r_rd2   <= w_rd2_nxt;
                r_busy1 <= w_pend_nxt[bus.ra1];
                r_busy2 <= w_pend_nxt[bus.ra2];
            end
        end
    end

    assign bus.rd1      = r_rd1;
    assign bus.rd2      = r_rd2;
    assign bus.rd_busy1 = r_busy1;
    assign bus.rd_busy2 = r_busy2;
    assign bus.rsv_ok   = w_rsv_ok;
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Directed and random checks of regfile_sb against an array model.
// Revision : 1.0
// ============================================================================
module tb_regfile_sb;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) b1 ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m0_regs [32];
    logic        m0_pend [32];
    logic [31:0] e0_rd1, e0_rd2;
    logic        e0_b1, e0_b2;
    logic [15:0] m1_regs [8];
    logic        m1_pend [8];
    logic [15:0] e1_rd1, e1_rd2;
    logic        e1_b1, e1_b2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m0_regs[i] = '0; m0_pend[i] = 1'b0; end
        for (int i = 0; i < 8; i++)  begin m1_regs[i] = '0; m1_pend[i] = 1'b0; end
        e0_rd1 = '0; e0_rd2 = '0; e0_b1 = 1'b0; e0_b2 = 1'b0;
        e1_rd1 = '0; e1_rd2 = '0; e1_b1 = 1'b0; e1_b2 = 1'b0;
    endtask

    task automatic chk_outputs();
        chk("rd1_0", b0.rd1, e0_rd1);
        chk("rd2_0", b0.rd2, e0_rd2);
        chk("busy1_0", {31'd0, b0.rd_busy1}, {31'd0, e0_b1});
        chk("busy2_0", {31'd0, b0.rd_busy2}, {31'd0, e0_b2});
        chk("rd1_1", {16'd0, b1.rd1}, {16'd0, e1_rd1});
        chk("rd2_1", {16'd0, b1.rd2}, {16'd0, e1_rd2});
        chk("busy1_1", {31'd0, b1.rd_busy1}, {31'd0, e1_b1});
        chk("busy2_1", {31'd0, b1.rd_busy2}, {31'd0, e1_b2});
    endtask

    // One clock on the 32x32 instance (register 0 hard-wired to zero).
    task automatic cyc0(input logic re, input logic [4:0] a1, input logic [4:0] a2,
                        input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [4:0] ra);
        logic ok;
        b1.rd_en = 1'b0; b1.we = 1'b0; b1.rsv_en = 1'b0;
        b0.rd_en = re; b0.ra1 = a1; b0.ra2 = a2;
        b0.we = w; b0.wa = wa; b0.wd = wd;
        b0.rsv_en = rv; b0.rsv_addr = ra;
        #2;
        ok = rv && (ra != 5'd0) && (!m0_pend[ra] || (w && wa == ra));
        chk("rsv_ok_0", {31'd0, b0.rsv_ok}, {31'd0, ok});
        @(posedge clk); #1;
        if (w && wa != 5'd0) begin m0_regs[wa] = wd; m0_pend[wa] = 1'b0; end
        if (ok) m0_pend[ra] = 1'b1;
        if (re) begin
            e0_rd1 = (a1 == 5'd0) ? 32'd0 : m0_regs[a1];
            e0_rd2 = (a2 == 5'd0) ? 32'd0 : m0_regs[a2];
            e0_b1  = m0_pend[a1];
            e0_b2  = m0_pend[a2];
        end
        chk_outputs();
    endtask

    // One clock on the 8x16 instance (register 0 ordinary).
    task automatic cyc1(input logic re, input logic [2:0] a1, input logic [2:0] a2,
                        input logic w, input logic [2:0] wa, input logic [15:0] wd,
                        input logic rv, input logic [2:0] ra);
        logic ok;
        b0.rd_en = 1'b0; b0.we = 1'b0; b0.rsv_en = 1'b0;
        b1.rd_en = re; b1.ra1 = a1; b1.ra2 = a2;
        b1.we = w; b1.wa = wa; b1.wd = wd;
        b1.rsv_en = rv; b1.rsv_addr = ra;
        #2;
        ok = rv && (!m1_pend[ra] || (w && wa == ra));
        chk("rsv_ok_1", {31'd0, b1.rsv_ok}, {31'd0, ok});
        @(posedge clk); #1;
        if (w) begin m1_regs[wa] = wd; m1_pend[wa] = 1'b0; end
        if (ok) m1_pend[ra] = 1'b1;
        if (re) begin
            e1_rd1 = m1_regs[a1];
            e1_rd2 = m1_regs[a2];
            e1_b1  = m1_pend[a1];
            e1_b2  = m1_pend[a2];
        end
        chk_outputs();
    endtask

    function automatic logic [4:0] rnd_a();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        b0.rd_en = 0; b0.ra1 = 0; b0.ra2 = 0; b0.we = 0; b0.wa = 0; b0.wd = 0; b0.rsv_en = 0; b0.rsv_addr = 0;
        b1.rd_en = 0; b1.ra1 = 0; b1.ra2 = 0; b1.we = 0; b1.wa = 0; b1.wd = 0; b1.rsv_en = 0; b1.rsv_addr = 0;
        model_reset();
        #12;
        chk_outputs();
        @(negedge clk); rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle.
        cyc0(1, 5, 5, 1, 5, 32'hDEADBEEF, 0, 0);
        #2; rst_n = 1'b0; #1;
        model_reset();
        chk_outputs();
        @(negedge clk); rst_n = 1'b1;
        cyc0(1, 5, 5, 0, 0, 0, 0, 0);

        // Bypass, then hold while rd_en is low.
        cyc0(1, 7, 7, 1, 7, 32'h12345678, 0, 0);
        cyc0(0, 7, 7, 1, 7, 32'h00000001, 0, 0);
        cyc0(1, 7, 3, 0, 0, 0, 0, 0);

        // Register 0 protected versus ordinary.
        cyc0(1, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
        cyc0(1, 0, 0, 0, 0, 0, 0, 0);
        cyc1(1, 0, 0, 1, 0, 16'hFFFF, 1, 0);
        cyc1(1, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard: reserve, read busy, refused re-reserve, release by write.
        cyc0(0, 0, 0, 0, 0, 0, 1, 3);
        cyc0(1, 3, 3, 0, 0, 0, 0, 0);
        cyc0(0, 0, 0, 0, 0, 0, 1, 3);
        cyc0(1, 3, 3, 1, 3, 32'h000000A5, 0, 0);

        // Write and re-reservation of the same register on one edge.
        cyc0(0, 0, 0, 0, 0, 0, 1, 9);
        cyc0(1, 9, 9, 1, 9, 32'h00000055, 1, 9);

        for (int n = 0; n < 400; n++)
            cyc0(($urandom_range(0, 3) != 0), rnd_a(), rnd_a(),
                 $urandom_range(0, 1) == 1, rnd_a(), $urandom,
                 $urandom_range(0, 1) == 1, rnd_a());

        // Narrow instance: fill all 8 registers, then read every pair.
        for (int i = 0; i < 8; i++)
            cyc1(0, 0, 0, 1, 3'(i), 16'h1000 + 16'(i) * 16'h0101, 0, 0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                cyc1(1, 3'(i), 3'(j), 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
